// File: rtl/audio_pkg.sv
// Shared audio-path definitions: clock rate, sample type and LFO direction codes.
package audio_pkg;

    localparam int unsigned CLK_HZ   = 50_000_000;
    localparam int          DATA_W   = 24;
    localparam int          LFO_BITS = 10;

    typedef logic signed [DATA_W-1:0] sample_t;

    // Triangle direction state: counting down toward 0, or up toward MAX.
    localparam logic [0:0] DIR_DOWN = 1'b0;
    localparam logic [0:0] DIR_UP   = 1'b1;

endpackage

// File: rtl/tremolo_lfo.sv
// Triangle LFO: a phase accumulator produces at most one tick per clock at
// 'frequency' ticks per second; each tick walks the triangle one step.
module tremolo_lfo
    import audio_pkg::*;
#(
    parameter int unsigned CLK_HZ   = audio_pkg::CLK_HZ,
    parameter int          LFO_BITS = audio_pkg::LFO_BITS
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                hold,
    input  logic [31:0]         frequency,
    output logic                tick,
    output logic [LFO_BITS-1:0] lfo_level
);

    localparam logic [LFO_BITS-1:0] MAX       = '1;
    localparam logic [31:0]         CLK_LIM   = 32'(CLK_HZ);
    localparam logic [32:0]         CLK_LIM33 = 33'(CLK_HZ);

    logic [31:0] acc;
    logic [31:0] freq_c;
    logic [32:0] sum;
    logic [0:0]  dir;

    // Clamp the rate to one tick per clock and decide whether this clock ticks.
    always_comb begin
        freq_c = (frequency > CLK_LIM) ? CLK_LIM : frequency;
        sum    = {1'b0, acc} + {1'b0, freq_c};
        tick   = !hold && (sum >= CLK_LIM33);
    end

    // Accumulator and triangle; hold pins everything at the reset state so
    // re-enabling restarts from full gain.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            acc       <= '0;
            lfo_level <= MAX;
            dir       <= DIR_DOWN;
        end else if (hold) begin
            acc       <= '0;
            lfo_level <= MAX;
            dir       <= DIR_DOWN;
        end else begin
            acc <= tick ? 32'(sum - CLK_LIM33) : sum[31:0];
            if (tick) begin
                if (dir == DIR_DOWN) begin
                    if (lfo_level == '0) begin
                        dir       <= DIR_UP;
                        lfo_level <= LFO_BITS'(1);
                    end else begin
                        lfo_level <= lfo_level - LFO_BITS'(1);
                    end
                end else begin
                    if (lfo_level == MAX) begin
                        dir       <= DIR_DOWN;
                        lfo_level <= MAX - LFO_BITS'(1);
                    end else begin
                        lfo_level <= lfo_level + LFO_BITS'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tremolo_modulator.sv
// Tremolo: scales each codec sample by a gain derived from the triangle LFO.
// Fixed two-clock latency, one sample accepted per clock.
//
// Handshake: in_valid is a one-clock strobe marking in_sample as valid; there
// is no ready (the codec cannot be stalled). out_valid is a one-clock strobe
// exactly two clocks after the matching in_valid; out_sample holds between
// strobes.
module tremolo_modulator
    import audio_pkg::*;
#(
    parameter int unsigned CLK_HZ      = audio_pkg::CLK_HZ,
    parameter int          DATA_W      = audio_pkg::DATA_W,
    parameter int          LFO_BITS    = audio_pkg::LFO_BITS,
    parameter int          DEPTH_SHIFT = 0
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     disabled,
    input  logic [31:0]              frequency,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_sample,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_sample,
    output logic [LFO_BITS-1:0]      lfo_level
);

    localparam int                  PROD_W = DATA_W + LFO_BITS + 1;
    localparam logic [LFO_BITS-1:0] MAX    = '1;

    logic                     lfo_tick;
    logic [LFO_BITS-1:0]      gain;
    logic                     s1_valid;
    logic                     s1_bypass;
    logic signed [DATA_W-1:0] s1_sample;
    logic [LFO_BITS-1:0]      s1_gain;
    logic signed [PROD_W-1:0] prod;
    logic signed [DATA_W-1:0] scaled;

    tremolo_lfo #(
        .CLK_HZ   (CLK_HZ),
        .LFO_BITS (LFO_BITS)
    ) u_lfo (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .hold      (disabled),
        .frequency (frequency),
        .tick      (lfo_tick),
        .lfo_level (lfo_level)
    );

    // Gain: depth shift shrinks the dip below MAX; gain stays under 2^LFO_BITS
    // so the rescaled product always fits back into DATA_W.
    always_comb begin
        gain   = MAX - ((MAX - lfo_level) >> DEPTH_SHIFT);
        prod   = PROD_W'(s1_sample) * PROD_W'($signed({1'b0, s1_gain}));
        scaled = DATA_W'(prod >>> LFO_BITS);
    end

    // Stage 1: capture the sample with the gain (or bypass flag) current at arrival.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_valid  <= 1'b0;
            s1_bypass <= 1'b0;
            s1_sample <= '0;
            s1_gain   <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sample <= in_sample;
                s1_gain   <= gain;
                s1_bypass <= disabled;
            end
        end
    end

    // Stage 2: multiply/rescale or pass through; output register holds between strobes.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            out_valid  <= 1'b0;
            out_sample <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sample <= s1_bypass ? s1_sample : scaled;
            end
        end
    end

endmodule
